// File: rtl/mem_responder.sv
// mem_responder: four-phase data/instruction memory responder with fixed access latency.
// Optional macro MEM_RESP_WINDOW_CHECK_EN flags out-of-window accesses; without it the array aliases.
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_data_i,
  input  logic        data_ren,
  input  logic        data_wen,
  output logic [31:0] data_data_o,
  output logic        data_ack,
  input  logic [31:0] inst_addr,
  input  logic        inst_ren,
  output logic [31:0] inst_data_o,
  output logic        inst_ack,
  output logic        bus_err,
  output logic [6:0]  resp_state
);
  // state   | meaning
  // IDLE    | waiting for a request on either port
  // ACCESS  | latency countdown, array access on terminal count
  // ACK     | ack high until the granted port drops its request
  // RELEASE | one idle cycle before the next acceptance
  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_ACCESS  = 4'b0010,
    S_ACK     = 4'b0100,
    S_RELEASE = 4'b1000
  } state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              gnt_inst;
  logic              last_inst;
  logic              lat_write;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       mem [DEPTH];

  logic              data_req;
  logic              inst_req;
  logic              pick_inst;
  logic              gnt_req;
  logic              commit;
  logic              oob;
  logic              mem_we;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rd_word;
  logic              unused_addr;

  assign data_req  = data_ren | data_wen;
  assign inst_req  = inst_ren;
  // On contention the port that lost the previous grant wins.
  assign pick_inst = inst_req & (~data_req | ~last_inst);
  assign gnt_req   = gnt_inst ? inst_req : data_req;
  assign commit    = (state == S_ACCESS) && (cnt == 4'd0);
  assign word_idx  = lat_addr[ADDR_W+1:2];

`ifdef MEM_RESP_WINDOW_CHECK_EN
  logic [31:0] win_addr;
  assign win_addr    = lat_addr & 32'h1FFF_FFFF;
  assign oob         = (win_addr >> (ADDR_W + 2)) != 32'd0;
  assign unused_addr = ^lat_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if (commit && oob) begin
      bus_err <= 1'b1;
    end
  end
`else
  assign oob         = 1'b0;
  assign bus_err     = 1'b0;
  assign unused_addr = ^{lat_addr[31:ADDR_W+2], lat_addr[1:0]};
`endif

  assign mem_we     = commit & lat_write & ~oob;
  assign rd_word    = oob ? 32'hDEAD_BEEF : mem[word_idx];
  assign resp_state = {3'b000, state};

  // Array has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_idx] <= lat_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      gnt_inst    <= 1'b0;
      last_inst   <= 1'b1;
      lat_write   <= 1'b0;
      lat_addr    <= 32'd0;
      lat_wdata   <= 32'd0;
      data_ack    <= 1'b0;
      inst_ack    <= 1'b0;
      data_data_o <= 32'd0;
      inst_data_o <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (data_req | inst_req) begin
            gnt_inst  <= pick_inst;
            last_inst <= pick_inst;
            lat_addr  <= pick_inst ? inst_addr : data_addr;
            lat_wdata <= data_data_i;
            lat_write <= ~pick_inst & data_wen;
            cnt       <= CNT_LOAD;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt == 4'd0) begin
            state <= S_ACK;
            if (gnt_inst) begin
              inst_ack    <= 1'b1;
              inst_data_o <= rd_word;
            end else begin
              data_ack <= 1'b1;
              if (!lat_write) begin
                data_data_o <= rd_word;
              end
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          if (!gnt_req) begin
            data_ack <= 1'b0;
            inst_ack <= 1'b0;
            state    <= S_RELEASE;
          end
        end
        S_RELEASE: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end
endmodule
